// File: rtl/ascon_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ascon_job_sequencer
//  Description : Host-side job controller for the integrated ASCON wrapper.
//                Accepts one job command and streams associated-data and
//                text beats into the wrapper's input FIFOs. The first
//                PRIME_DEPTH beats of each stream are written before the
//                start pulse. It then drains the cipher FIFO into a
//                ready/valid output stream and reports completion status.
//                A core that never signals done is aborted through a
//                two-cycle core reset.
//  Ports       : clock, n_reset               clock / async active-low reset
//                cmd_*                        job command (accepted in IDLE)
//                ad_*, txt_*                  128-bit input streams
//                out_*                        128-bit result stream
//                core_mode/start/reset        core control
//                data_wr*, text_wr*, *_afull  wrapper FIFO write side
//                result, result_empty/rd_en   cipher FIFO (first-word-fall-through)
//                core_done/warning/tag_valid  core status inputs
//                sts_*                        one-cycle job-complete report
//                busy                         high whenever not IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module ascon_job_sequencer #(
    parameter int CNT_W       = 8,
    parameter int PRIME_DEPTH = 2,
    parameter int TIMEOUT_CYC = 4096,
    parameter int TMO_W       = 16
) (
    input  logic               clock,
    input  logic               n_reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_mode,
    input  logic [CNT_W-1:0]   cmd_ad_blocks,
    input  logic [CNT_W-1:0]   cmd_txt_blocks,
    input  logic [CNT_W-1:0]   cmd_res_blocks,
    input  logic               ad_valid,
    output logic               ad_ready,
    input  logic [127:0]       ad_data,
    input  logic               txt_valid,
    output logic               txt_ready,
    input  logic [127:0]       txt_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_data,
    output logic [2:0]         core_mode,
    output logic               core_start,
    output logic               core_reset,
    output logic [127:0]       data_wr,
    output logic               data_wr_en,
    output logic [127:0]       text_wr,
    output logic               text_wr_en,
    input  logic               data_afull,
    input  logic               text_afull,
    input  logic [127:0]       result,
    input  logic               result_empty,
    output logic               result_rd_en,
    input  logic               core_done,
    input  logic               core_warning,
    input  logic               core_tag_valid,
    output logic               sts_valid,
    output logic               sts_warning,
    output logic               sts_tag_valid,
    output logic               sts_timeout,
    output logic               busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_START  = 3'd2,
        ST_RUN    = 3'd3,
        ST_ABORT  = 3'd4,
        ST_REPORT = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] C_PRIME    = CNT_W'(PRIME_DEPTH);
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_t             r_state, w_state_next;
    logic [2:0]         r_mode;
    logic [CNT_W-1:0]   r_ad_blocks, r_txt_blocks, r_res_blocks;
    logic [CNT_W-1:0]   r_ad_sent, r_txt_sent, r_res_cnt;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_done_seen, r_warn, r_tag, r_timeout, r_abort_cnt;
    logic               r_out_valid;
    logic [127:0]       r_out_data;

    logic               w_fwd, w_prime, w_run, w_done, w_all_in;
    logic [CNT_W-1:0]   w_ad_prime, w_txt_prime, w_ad_lim, w_txt_lim;

    // Forwarding is open in PRIME and RUN; PRIME caps each stream at the
    // priming depth so the core starts with a known fill level.
    assign w_prime     = (r_state == ST_PRIME);
    assign w_run       = (r_state == ST_RUN);
    assign w_fwd       = w_prime | w_run;
    assign w_ad_prime  = (r_ad_blocks  < C_PRIME) ? r_ad_blocks  : C_PRIME;
    assign w_txt_prime = (r_txt_blocks < C_PRIME) ? r_txt_blocks : C_PRIME;
    assign w_ad_lim    = w_prime ? w_ad_prime  : r_ad_blocks;
    assign w_txt_lim   = w_prime ? w_txt_prime : r_txt_blocks;

    assign ad_ready    = w_fwd & (r_ad_sent  < w_ad_lim)  & ~data_afull;
    assign txt_ready   = w_fwd & (r_txt_sent < w_txt_lim) & ~text_afull;
    assign data_wr_en  = ad_valid  & ad_ready;
    assign text_wr_en  = txt_valid & txt_ready;
    assign data_wr     = w_fwd ? ad_data  : '0;
    assign text_wr     = w_fwd ? txt_data : '0;

    // Pop only when the output register is free or is emptying this cycle.
    assign result_rd_en = w_run & ~result_empty & (r_res_cnt < r_res_blocks)
                        & (~r_out_valid | out_ready);

    // Done seen this cycle counts, so REPORT follows core_done by one cycle.
    assign w_done   = r_done_seen | core_done;
    assign w_all_in = (r_ad_sent == r_ad_blocks) && (r_txt_sent == r_txt_blocks);

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign core_mode = r_mode;
    assign busy      = (r_state != ST_IDLE);

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        cmd_ready     = 1'b0;
        core_start    = 1'b0;
        core_reset    = 1'b0;
        sts_valid     = 1'b0;
        sts_warning   = 1'b0;
        sts_tag_valid = 1'b0;
        sts_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_state_next = ST_PRIME;
            end
            ST_PRIME: begin
                if ((r_ad_sent == w_ad_prime) && (r_txt_sent == w_txt_prime))
                    w_state_next = ST_START;
            end
            ST_START: begin
                core_start   = 1'b1;
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_done && w_all_in && (r_res_cnt == r_res_blocks) && !r_out_valid)
                    w_state_next = ST_REPORT;
                else if (!w_done && (r_tmo_cnt == C_TMO_LAST))
                    w_state_next = ST_ABORT;
            end
            ST_ABORT: begin
                core_reset = 1'b1;
                if (r_abort_cnt) w_state_next = ST_REPORT;
            end
            ST_REPORT: begin
                sts_valid     = 1'b1;
                sts_warning   = r_warn;
                sts_tag_valid = r_tag;
                sts_timeout   = r_timeout;
                w_state_next  = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_mode       <= '0;
            r_ad_blocks  <= '0;
            r_txt_blocks <= '0;
            r_res_blocks <= '0;
            r_ad_sent    <= '0;
            r_txt_sent   <= '0;
            r_res_cnt    <= '0;
            r_tmo_cnt    <= '0;
            r_done_seen  <= 1'b0;
            r_warn       <= 1'b0;
            r_tag        <= 1'b0;
            r_timeout    <= 1'b0;
            r_abort_cnt  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
        end else begin
            if ((r_state == ST_IDLE) && cmd_valid) begin
                r_mode       <= cmd_mode;
                r_ad_blocks  <= cmd_ad_blocks;
                r_txt_blocks <= cmd_txt_blocks;
                r_res_blocks <= cmd_res_blocks;
                r_ad_sent    <= '0;
                r_txt_sent   <= '0;
                r_res_cnt    <= '0;
                r_done_seen  <= 1'b0;
                r_warn       <= 1'b0;
                r_tag        <= 1'b0;
                r_timeout    <= 1'b0;
            end

            if (data_wr_en) r_ad_sent  <= r_ad_sent  + CNT_W'(1);
            if (text_wr_en) r_txt_sent <= r_txt_sent + CNT_W'(1);

            if (r_state == ST_START)
                r_tmo_cnt <= '0;
            else if (w_run && !w_done)
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);

            if (w_run) begin
                r_done_seen <= r_done_seen | core_done;
                r_warn      <= r_warn | core_warning;
                r_tag       <= r_tag  | core_tag_valid;
                if (w_state_next == ST_ABORT) r_timeout <= 1'b1;
            end

            if (result_rd_en) begin
                r_out_data  <= result;
                r_out_valid <= 1'b1;
                r_res_cnt   <= r_res_cnt + CNT_W'(1);
            end else if ((r_state == ST_ABORT) || out_ready) begin
                r_out_valid <= 1'b0;
            end

            r_abort_cnt <= (r_state == ST_ABORT) ? ~r_abort_cnt : 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ascon_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ascon_job_sequencer
//  Description : Scoreboard bench for ascon_job_sequencer. Jobs push their
//                expected FIFO writes, result beats and status into queues;
//                a negedge monitor pops and compares as the DUT presents them.
//                Behavioural models stand in for the cipher FIFO and the core.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ascon_job_sequencer;

    logic         clock = 1'b0;
    logic         n_reset = 1'b0;
    logic         cmd_valid = 1'b0, cmd_ready;
    logic [2:0]   cmd_mode = '0;
    logic [7:0]   cmd_ad_blocks = '0, cmd_txt_blocks = '0, cmd_res_blocks = '0;
    logic         ad_valid = 1'b1, ad_ready, txt_valid = 1'b1, txt_ready;
    logic [127:0] ad_data, txt_data;
    logic         out_valid, out_ready = 1'b1;
    logic [127:0] out_data;
    logic [2:0]   core_mode;
    logic         core_start, core_reset;
    logic [127:0] data_wr, text_wr;
    logic         data_wr_en, text_wr_en;
    logic         data_afull = 1'b0, text_afull = 1'b0;
    logic [127:0] result;
    logic         result_empty, result_rd_en;
    logic         core_done, core_warning, core_tag_valid;
    logic         sts_valid, sts_warning, sts_tag_valid, sts_timeout, busy;

    always #5 clock = ~clock;

    ascon_job_sequencer dut (
        .clock(clock), .n_reset(n_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_ad_blocks(cmd_ad_blocks), .cmd_txt_blocks(cmd_txt_blocks),
        .cmd_res_blocks(cmd_res_blocks),
        .ad_valid(ad_valid), .ad_ready(ad_ready), .ad_data(ad_data),
        .txt_valid(txt_valid), .txt_ready(txt_ready), .txt_data(txt_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .core_mode(core_mode), .core_start(core_start), .core_reset(core_reset),
        .data_wr(data_wr), .data_wr_en(data_wr_en),
        .text_wr(text_wr), .text_wr_en(text_wr_en),
        .data_afull(data_afull), .text_afull(text_afull),
        .result(result), .result_empty(result_empty), .result_rd_en(result_rd_en),
        .core_done(core_done), .core_warning(core_warning), .core_tag_valid(core_tag_valid),
        .sts_valid(sts_valid), .sts_warning(sts_warning), .sts_tag_valid(sts_tag_valid),
        .sts_timeout(sts_timeout), .busy(busy)
    );

    int n_pass = 0, n_chk = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [127:0] mk(input logic [31:0] tag, input int idx);
        return {tag, 96'(idx)};
    endfunction

    // Input stream sources: beat index advances on each accepted handshake.
    int ad_idx = 0, txt_idx = 0;
    assign ad_data  = mk(32'hADAD_0000, ad_idx);
    assign txt_data = mk(32'hC0DE_0000, txt_idx);
    always @(posedge clock) begin
        if (ad_valid && ad_ready)   ad_idx  <= ad_idx + 1;
        if (txt_valid && txt_ready) txt_idx <= txt_idx + 1;
    end

    // Cipher FIFO model (first-word-fall-through).
    logic [127:0] rmem [0:63];
    int rwp = 0, rrp = 0;
    logic [5:0] rrp_i;
    assign rrp_i        = rrp[5:0];
    assign result       = rmem[rrp_i];
    assign result_empty = (rwp == rrp);
    always @(posedge clock) if (result_rd_en && (rwp != rrp)) rrp <= rrp + 1;

    // Core model: core_done fires done_delay RUN cycles after core_start; 0 = never.
    int done_delay = 0, cdn = 0;
    logic warn_flag = 1'b0, tag_flag = 1'b0;
    always @(posedge clock) begin
        if (!n_reset || core_reset) cdn <= 0;
        else if (core_start)        cdn <= done_delay;
        else if (cdn > 0)           cdn <= cdn - 1;
    end
    assign core_done      = (cdn == 1);
    assign core_warning   = core_done & warn_flag;
    assign core_tag_valid = core_done & tag_flag;

    logic [127:0] adq[$], txtq[$], outq[$];
    logic [2:0]   stsq[$];
    logic [2:0]   mode_exp = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor / scoreboard
    int ad_wr_cnt = 0, txt_wr_cnt = 0, out_cnt = 0, start_cnt = 0, sts_cnt = 0, rst_cycles = 0;
    int ad_at_start = 0, txt_at_start = 0;
    int acc_cyc = 0, start_cyc = 0, done_cyc = 0, sts_cyc = 0, rst_first = 0;
    logic prev_core_reset = 1'b0;
    always @(negedge clock) begin
        if (n_reset) begin
            if (data_wr_en) begin
                if (adq.size() == 0) check("ad_unexpected_write", data_wr, '0);
                else check("ad_beat", data_wr, adq.pop_front());
                ad_wr_cnt++;
            end
            if (text_wr_en) begin
                if (txtq.size() == 0) check("txt_unexpected_write", text_wr, '0);
                else check("txt_beat", text_wr, txtq.pop_front());
                txt_wr_cnt++;
            end
            if (out_valid && out_ready) begin
                if (outq.size() == 0) check("out_unexpected_beat", out_data, '0);
                else check("out_beat", out_data, outq.pop_front());
                out_cnt++;
            end
            if (out_valid && !out_ready) check("rd_en_held_off", result_rd_en, 0);
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (core_start) begin
                start_cnt++;
                start_cyc    = cyc;
                ad_at_start  = ad_wr_cnt;
                txt_at_start = txt_wr_cnt;
                check("start_mode", core_mode, mode_exp);
            end
            if (core_done) done_cyc = cyc;
            if (core_reset) begin
                if (!prev_core_reset) rst_first = cyc;
                rst_cycles++;
            end
            if (sts_valid) begin
                sts_cnt++;
                sts_cyc = cyc;
                if (stsq.size() == 0) check("sts_unexpected", 1, 0);
                else check("sts_flags", {sts_warning, sts_tag_valid, sts_timeout}, stsq.pop_front());
            end
        end
        prev_core_reset = core_reset;
    end

    function automatic logic [16:0] outs();
        return {cmd_ready, busy, core_start, core_reset, sts_valid, sts_warning,
                sts_tag_valid, sts_timeout, ad_ready, txt_ready, out_valid,
                result_rd_en, data_wr_en, text_wr_en, core_mode};
    endfunction

    int s_ad, s_txt, s_out, s_start, s_rst;

    task automatic issue(input logic [2:0] m, input int na, input int nt, input int nr,
                         input int dly, input bit exp_sts, input logic [2:0] sts);
        for (int i = 0; i < na; i++) adq.push_back(mk(32'hADAD_0000, ad_idx + i));
        for (int i = 0; i < nt; i++) txtq.push_back(mk(32'hC0DE_0000, txt_idx + i));
        for (int i = 0; i < nr; i++) begin
            logic [5:0] wi;
            wi = rwp[5:0];
            rmem[wi] = mk(32'hBEEF_0000, rwp);
            outq.push_back(mk(32'hBEEF_0000, rwp));
            rwp++;
        end
        if (exp_sts) stsq.push_back(sts);
        mode_exp   = m;
        done_delay = dly;
        s_ad = ad_wr_cnt; s_txt = txt_wr_cnt; s_out = out_cnt; s_start = start_cnt; s_rst = rst_cycles;
        cmd_mode = m; cmd_ad_blocks = 8'(na); cmd_txt_blocks = 8'(nt); cmd_res_blocks = 8'(nr);
        cmd_valid = 1'b1;
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_sts(input int n, input int bound);
        int k = 0;
        while (sts_cnt < n && k < bound) begin @(posedge clock); k++; end
        #1;
        check("sts_arrived", sts_cnt >= n, 1);
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", outs(), 17'h10000);
        check("reset_out_data", out_data, '0);
        check("reset_data_wr", data_wr, '0);
        n_reset = 1'b1;
        @(posedge clock); #1;

        // Job 1: 2 AD, 3 text, 3 results, done 10 cycles after start.
        issue(3'd5, 2, 3, 3, 10, 1'b1, 3'b000);
        wait_sts(1, 200);
        check("j1_ad_before_start", ad_at_start - s_ad, 2);
        check("j1_txt_before_start", txt_at_start - s_txt, 2);
        check("j1_start_once", start_cnt - s_start, 1);
        check("j1_out_beats", out_cnt - s_out, 3);
        check("j1_txt_total", txt_wr_cnt - s_txt, 3);

        // Job 2: output back-pressure for 20 cycles mid-drain.
        issue(3'd2, 1, 1, 4, 30, 1'b1, 3'b000);
        k = 0;
        while (out_cnt < s_out + 1 && k < 200) begin @(posedge clock); k++; end
        #1;
        out_ready = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check("j2_out_held", out_valid, 1);
        out_ready = 1'b1;
        wait_sts(2, 200);
        check("j2_out_beats", out_cnt - s_out, 4);

        // Job 3: AD FIFO almost-full during PRIME withholds the start.
        data_afull = 1'b1;
        issue(3'd1, 2, 0, 0, 3, 1'b1, 3'b000);
        repeat (10) @(posedge clock);
        #1;
        check("j3_ad_ready_blocked", ad_ready, 0);
        check("j3_no_start", start_cnt - s_start, 0);
        check("j3_busy", busy, 1);
        data_afull = 1'b0;
        wait_sts(3, 200);
        check("j3_ad_before_start", ad_at_start - s_ad, 2);

        // Job 4: empty job; tag_valid reported with done.
        tag_flag = 1'b1;
        issue(3'd3, 0, 0, 0, 3, 1'b1, 3'b010);
        wait_sts(4, 200);
        tag_flag = 1'b0;
        check("j4_prime_to_start", start_cyc - acc_cyc, 2);
        check("j4_done_to_report", sts_cyc - done_cyc, 1);

        // Job 5: core never done -> timeout abort.
        issue(3'd4, 0, 0, 0, 0, 1'b1, 3'b001);
        wait_sts(5, 6000);
        check("j5_abort_latency", rst_first - start_cyc, 4097);
        check("j5_core_reset_len", rst_cycles - s_rst, 2);
        check("j5_report_latency", sts_cyc - start_cyc, 4099);
        check("j5_cmd_ready_after", cmd_ready, 1);

        // Job 6: asynchronous reset during RUN; no status expected.
        issue(3'd6, 1, 1, 0, 0, 1'b0, 3'b000);
        k = 0;
        while (start_cnt == s_start && k < 100) begin @(posedge clock); k++; end
        check("j6_started", start_cnt - s_start, 1);
        repeat (3) @(posedge clock);
        #3;
        n_reset = 1'b0;
        #1;
        check("j6_async_reset_outputs", outs(), 17'h10000);
        adq.delete();
        txtq.delete();
        repeat (2) @(posedge clock);
        #1;
        n_reset = 1'b1;
        @(posedge clock); #1;

        // Job 7: clean job after reset; flags from earlier jobs must not leak.
        issue(3'd7, 1, 1, 1, 5, 1'b1, 3'b000);
        wait_sts(6, 200);
        check("j7_out_beats", out_cnt - s_out, 1);

        repeat (5) @(posedge clock);
        #1;
        check("left_out", outq.size(), 0);
        check("left_sts", stsq.size(), 0);
        check("left_ad", adq.size(), 0);
        check("left_txt", txtq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
